// File: rtl/video_window_calc.sv
// rtl/video_window_calc.sv - centred display window from an aspect-ratio descriptor and the output resolution
// Results are staged by a serial multiply/divide datapath and committed only on an output VS rising edge.
module video_window_calc (
  input  logic        CLK_VIDEO,
  input  logic        RESET_N,
  input  logic        VS,
  input  logic [11:0] HDMI_WIDTH,
  input  logic [11:0] HDMI_HEIGHT,
  input  logic [12:0] ARX,
  input  logic [12:0] ARY,
  output logic        CALC_DONE,
  output logic        WIN_VALID,
  output logic [11:0] HMIN,
  output logic [11:0] HMAX,
  output logic [11:0] VMIN,
  output logic [11:0] VMAX
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MUL1   = 3'd2,
    S_DIV1   = 3'd3,
    S_MUL2   = 3'd4,
    S_DIV2   = 3'd5,
    S_CENTER = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_pending;
  logic [12:0] r_snap_arx;
  logic [12:0] r_snap_ary;
  logic [11:0] r_snap_w;
  logic [11:0] r_snap_h;
  logic [4:0]  r_cnt;
  logic [23:0] r_acc;
  logic [23:0] r_mcand;
  logic [11:0] r_mplier;
  logic [23:0] r_quo;
  logic [11:0] r_rem;
  logic [11:0] r_w;
  logic [11:0] r_h;
  logic [11:0] r_hmin_s;
  logic [11:0] r_hmax_s;
  logic [11:0] r_vmin_s;
  logic [11:0] r_vmax_s;
  logic        r_done;
  logic        r_new;
  logic        r_vs;
  logic        r_vs_d;
  logic        r_valid;
  logic [11:0] r_hmin;
  logic [11:0] r_hmax;
  logic [11:0] r_vmin;
  logic [11:0] r_vmax;

  logic        w_change;
  logic        w_abs;
  logic        w_full;
  logic [11:0] w_abs_w;
  logic [11:0] w_abs_h;
  logic [23:0] w_pp;
  logic [23:0] w_prod;
  logic [11:0] w_divisor;
  logic [12:0] w_shift;
  logic        w_ge;
  logic [11:0] w_rem_next;
  logic [23:0] w_quo_next;
  logic        w_last_mul;
  logic        w_last_div;
  logic        w_q_fits;
  logic [11:0] w_w_div1;
  logic [11:0] w_h_div2;
  logic [11:0] w_hmin;
  logic [11:0] w_vmin;
  logic        w_vs_rise;

  assign w_change = (ARX != r_snap_arx) || (ARY != r_snap_ary) ||
                    (HDMI_WIDTH != r_snap_w) || (HDMI_HEIGHT != r_snap_h);

  // Any bit12 switches both fields to absolute sizes; a zero field means full dimension.
  assign w_abs   = ARX[12] | ARY[12];
  assign w_full  = !w_abs && ((ARX[11:0] == 12'd0) || (ARY[11:0] == 12'd0));
  assign w_abs_w = ((ARX[11:0] == 12'd0) || (ARX[11:0] > HDMI_WIDTH))  ? HDMI_WIDTH  : ARX[11:0];
  assign w_abs_h = ((ARY[11:0] == 12'd0) || (ARY[11:0] > HDMI_HEIGHT)) ? HDMI_HEIGHT : ARY[11:0];

  assign w_pp       = r_mplier[0] ? r_mcand : 24'd0;
  assign w_prod     = r_acc + w_pp;
  assign w_divisor  = (r_state == S_DIV2) ? r_snap_arx[11:0] : r_snap_ary[11:0];
  assign w_shift    = {r_rem, r_quo[23]};
  assign w_ge       = (w_shift >= {1'b0, w_divisor});
  // When the trial subtract succeeds the remainder is below the divisor, so 12 bits suffice.
  assign w_rem_next = w_ge ? (w_shift[11:0] - w_divisor) : w_shift[11:0];
  assign w_quo_next = {r_quo[22:0], w_ge};
  assign w_last_mul = (r_cnt == 5'd11);
  assign w_last_div = (r_cnt == 5'd23);
  assign w_q_fits   = (w_quo_next <= {12'd0, r_snap_w});
  assign w_w_div1   = (w_quo_next == 24'd0) ? 12'd1 : w_quo_next[11:0];
  assign w_h_div2   = (w_quo_next > {12'd0, r_snap_h}) ? r_snap_h :
                      ((w_quo_next == 24'd0) ? 12'd1 : w_quo_next[11:0]);

  assign w_hmin = (r_snap_w - r_w) >> 1;
  assign w_vmin = (r_snap_h - r_h) >> 1;

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_pending || w_change) w_next = S_LOAD;
      S_LOAD:   w_next = (w_full || w_abs) ? S_CENTER : S_MUL1;
      S_MUL1:   if (w_last_mul) w_next = S_DIV1;
      S_DIV1:   if (w_last_div) w_next = w_q_fits ? S_CENTER : S_MUL2;
      S_MUL2:   if (w_last_mul) w_next = S_DIV2;
      S_DIV2:   if (w_last_div) w_next = S_CENTER;
      S_CENTER: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pending  <= 1'b1;
      r_snap_arx <= 13'd0;
      r_snap_ary <= 13'd0;
      r_snap_w   <= 12'd0;
      r_snap_h   <= 12'd0;
      r_cnt      <= 5'd0;
      r_acc      <= 24'd0;
      r_mcand    <= 24'd0;
      r_mplier   <= 12'd0;
      r_quo      <= 24'd0;
      r_rem      <= 12'd0;
      r_w        <= 12'd0;
      r_h        <= 12'd0;
      r_hmin_s   <= 12'd0;
      r_hmax_s   <= 12'd0;
      r_vmin_s   <= 12'd0;
      r_vmax_s   <= 12'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_CENTER);
      case (r_state)
        S_IDLE: begin
          if (r_pending || w_change) r_pending <= 1'b0;
        end
        S_LOAD: begin
          r_snap_arx <= ARX;
          r_snap_ary <= ARY;
          r_snap_w   <= HDMI_WIDTH;
          r_snap_h   <= HDMI_HEIGHT;
          r_cnt      <= 5'd0;
          r_acc      <= 24'd0;
          r_mcand    <= {12'd0, HDMI_HEIGHT};
          r_mplier   <= ARX[11:0];
          if (w_full) begin
            r_w <= HDMI_WIDTH;
            r_h <= HDMI_HEIGHT;
          end else if (w_abs) begin
            r_w <= w_abs_w;
            r_h <= w_abs_h;
          end
        end
        S_MUL1, S_MUL2: begin
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last_mul) begin
            r_quo <= w_prod;
            r_rem <= 12'd0;
            r_cnt <= 5'd0;
          end else begin
            r_acc <= w_prod;
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DIV1, S_DIV2: begin
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= w_last_div ? 5'd0 : r_cnt + 5'd1;
          if (w_last_div) begin
            if (r_state == S_DIV2) begin
              r_w <= r_snap_w;
              r_h <= w_h_div2;
            end else if (w_q_fits) begin
              r_w <= w_w_div1;
              r_h <= r_snap_h;
            end else begin
              // Too wide for the screen: solve for height from the full width instead.
              r_acc    <= 24'd0;
              r_mcand  <= {12'd0, r_snap_w};
              r_mplier <= r_snap_ary[11:0];
            end
          end
        end
        S_CENTER: begin
          r_hmin_s <= w_hmin;
          r_hmax_s <= w_hmin + r_w - 12'd1;
          r_vmin_s <= w_vmin;
          r_vmax_s <= w_vmin + r_h - 12'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_vs_rise = r_vs & ~r_vs_d;

  // r_new rises only after the CALC_DONE cycle, so a coincident VS edge leaves the result waiting.
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vs    <= 1'b0;
      r_vs_d  <= 1'b0;
      r_new   <= 1'b0;
      r_valid <= 1'b0;
      r_hmin  <= 12'd0;
      r_hmax  <= 12'd0;
      r_vmin  <= 12'd0;
      r_vmax  <= 12'd0;
    end else begin
      r_vs   <= VS;
      r_vs_d <= r_vs;
      if (w_vs_rise && r_new) begin
        r_hmin  <= r_hmin_s;
        r_hmax  <= r_hmax_s;
        r_vmin  <= r_vmin_s;
        r_vmax  <= r_vmax_s;
        r_valid <= 1'b1;
      end
      if (r_done) begin
        r_new <= 1'b1;
      end else if (w_vs_rise && r_new) begin
        r_new <= 1'b0;
      end
    end
  end

  assign CALC_DONE = r_done;
  assign WIN_VALID = r_valid;
  assign HMIN      = r_hmin;
  assign HMAX      = r_hmax;
  assign VMIN      = r_vmin;
  assign VMAX      = r_vmax;

endmodule

// File: tb/tb_video_window_calc.sv
// tb/tb_video_window_calc.sv - directed and randomized checks of video_window_calc against an arithmetic model
module tb_video_window_calc;

  logic        CLK_VIDEO = 1'b0;
  logic        RESET_N;
  logic        VS;
  logic [11:0] HDMI_WIDTH;
  logic [11:0] HDMI_HEIGHT;
  logic [12:0] ARX;
  logic [12:0] ARY;
  logic        CALC_DONE;
  logic        WIN_VALID;
  logic [11:0] HMIN;
  logic [11:0] HMAX;
  logic [11:0] VMIN;
  logic [11:0] VMAX;

  int n_tests = 0;
  int n_fail  = 0;

  video_window_calc dut (
    .CLK_VIDEO  (CLK_VIDEO),
    .RESET_N    (RESET_N),
    .VS         (VS),
    .HDMI_WIDTH (HDMI_WIDTH),
    .HDMI_HEIGHT(HDMI_HEIGHT),
    .ARX        (ARX),
    .ARY        (ARY),
    .CALC_DONE  (CALC_DONE),
    .WIN_VALID  (WIN_VALID),
    .HMIN       (HMIN),
    .HMAX       (HMAX),
    .VMIN       (VMIN),
    .VMAX       (VMAX)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Window rules evaluated directly with integer arithmetic.
  function automatic void model(input int w_scr, input int h_scr, input int ax, input int ay,
                                output int hmin, output int hmax, output int vmin,
                                output int vmax, output int lat);
    int axl, ayl, w, h, q;
    axl = ax & 4095;
    ayl = ay & 4095;
    if (((ax & 4096) != 0) || ((ay & 4096) != 0)) begin
      w = (axl == 0 || axl > w_scr) ? w_scr : axl;
      h = (ayl == 0 || ayl > h_scr) ? h_scr : ayl;
      lat = 3;
    end else if (axl == 0 || ayl == 0) begin
      w = w_scr;
      h = h_scr;
      lat = 3;
    end else begin
      q = (h_scr * axl) / ayl;
      if (q <= w_scr) begin
        w = (q < 1) ? 1 : q;
        h = h_scr;
        lat = 39;
      end else begin
        q = (w_scr * ayl) / axl;
        h = (q > h_scr) ? h_scr : q;
        if (h < 1) h = 1;
        w = w_scr;
        lat = 75;
      end
    end
    hmin = (w_scr - w) / 2;
    hmax = hmin + w - 1;
    vmin = (h_scr - h) / 2;
    vmax = vmin + h - 1;
  endfunction

  task automatic apply(input int w_scr, input int h_scr, input int ax, input int ay);
    HDMI_WIDTH  = w_scr[11:0];
    HDMI_HEIGHT = h_scr[11:0];
    ARX         = ax[12:0];
    ARY         = ay[12:0];
  endtask

  // Counts negedges until CALC_DONE; optionally raises VS at negedge vs_at.
  task automatic run_calc(input string tag, input int exp_lat, input int vs_at);
    int k;
    bit found;
    k = 0;
    found = 0;
    while (k < 200 && !found) begin
      @(negedge CLK_VIDEO);
      k++;
      if (k == vs_at) VS = 1'b1;
      if (CALC_DONE) found = 1;
    end
    check_eq({tag, " latency"}, k, exp_lat);
  endtask

  task automatic pulse_vs();
    VS = 1'b1;
    repeat (2) @(negedge CLK_VIDEO);
    VS = 1'b0;
    repeat (2) @(negedge CLK_VIDEO);
  endtask

  task automatic check_win(input string tag, input int hmin, input int hmax,
                           input int vmin, input int vmax);
    check_eq({tag, " HMIN"}, HMIN, hmin);
    check_eq({tag, " HMAX"}, HMAX, hmax);
    check_eq({tag, " VMIN"}, VMIN, vmin);
    check_eq({tag, " VMAX"}, VMAX, vmax);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cw, ch, cax, cay;
    int w, h, ax, ay, mode, e_hmin, e_hmax, e_vmin, e_vmax, e_lat;

    RESET_N = 1'b0;
    VS      = 1'b0;
    apply(1920, 1080, 4, 3);
    repeat (3) @(negedge CLK_VIDEO);
    check_eq("reset CALC_DONE", CALC_DONE, 0);
    check_eq("reset WIN_VALID", WIN_VALID, 0);
    check_win("reset", 0, 0, 0, 0);

    RESET_N = 1'b1;
    run_calc("4:3", 39, 0);
    check_eq("4:3 precommit WIN_VALID", WIN_VALID, 0);
    pulse_vs();
    check_win("4:3", 240, 1679, 0, 1079);
    check_eq("4:3 WIN_VALID", WIN_VALID, 1);

    apply(1920, 1080, 21, 9);
    run_calc("21:9", 75, 0);
    pulse_vs();
    check_win("21:9", 0, 1919, 129, 950);

    apply(1920, 1080, 4096 | 1280, 4096 | 960);
    run_calc("abs", 3, 0);
    pulse_vs();
    check_win("abs", 320, 1599, 60, 1019);

    apply(1920, 1080, 0, 3);
    run_calc("full", 3, 0);
    pulse_vs();
    check_win("full", 0, 1919, 0, 1079);
    apply(1920, 1080, 0, 0);
    run_calc("full0", 3, 0);
    pulse_vs();
    check_win("full0", 0, 1919, 0, 1079);

    apply(1920, 1080, 4, 3);
    run_calc("gate 4:3", 39, 0);
    pulse_vs();
    check_win("gate 4:3", 240, 1679, 0, 1079);
    apply(1920, 1080, 16, 9);
    run_calc("gate 16:9", 39, 0);
    repeat (5) @(negedge CLK_VIDEO);
    check_win("gate held", 240, 1679, 0, 1079);
    pulse_vs();
    check_win("gate 16:9", 0, 1919, 0, 1079);

    apply(1920, 1080, 4, 3);
    run_calc("coincide", 39, 38);
    @(negedge CLK_VIDEO);
    check_win("coincide held", 0, 1919, 0, 1079);
    VS = 1'b0;
    repeat (2) @(negedge CLK_VIDEO);
    pulse_vs();
    check_win("coincide next", 240, 1679, 0, 1079);

    apply(1920, 1080, 5, 4);
    repeat (20) @(negedge CLK_VIDEO);
    RESET_N = 1'b0;
    #1;
    check_eq("midreset WIN_VALID", WIN_VALID, 0);
    check_eq("midreset CALC_DONE", CALC_DONE, 0);
    check_win("midreset", 0, 0, 0, 0);
    @(negedge CLK_VIDEO);
    RESET_N = 1'b1;
    run_calc("after reset", 39, 0);
    pulse_vs();
    check_win("after reset", 285, 1634, 0, 1079);
    check_eq("after reset WIN_VALID", WIN_VALID, 1);

    cw = 1920; ch = 1080; cax = 5; cay = 4;
    for (int i = 0; i < 24; i++) begin
      w    = $urandom_range(4000, 16);
      h    = $urandom_range(4000, 16);
      mode = $urandom_range(2, 0);
      if (mode == 0) begin
        ax = $urandom_range(4095, 1);
        ay = $urandom_range(4095, 1);
      end else if (mode == 1) begin
        ax = 4096 | $urandom_range(4095, 0);
        ay = ($urandom_range(1, 0) == 1) ? (4096 | $urandom_range(4095, 0)) : $urandom_range(4095, 0);
      end else begin
        ax = ($urandom_range(1, 0) == 1) ? 0 : $urandom_range(4095, 0);
        ay = (ax == 0) ? $urandom_range(4095, 0) : 0;
      end
      if (w == cw && h == ch && ax == cax && ay == cay) w = w + 1;
      cw = w; ch = h; cax = ax; cay = ay;
      model(w, h, ax, ay, e_hmin, e_hmax, e_vmin, e_vmax, e_lat);
      apply(w, h, ax, ay);
      run_calc($sformatf("rnd%0d", i), e_lat, 0);
      pulse_vs();
      check_win($sformatf("rnd%0d", i), e_hmin, e_hmax, e_vmin, e_vmax);
      check_eq($sformatf("rnd%0d WIN_VALID", i), WIN_VALID, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_window_calc.md
# video_window_calc

Output-side consumer of the aspect-ratio descriptor (VIDEO_ARX/VIDEO_ARY) produced by the input-side crop/scale analysis. It converts the descriptor and the HDMI output resolution into a centred display window (HMIN/HMAX/VMIN/VMAX) for the output scaler. It uses its own serial multiplier and divider. New results are committed only at an output vertical-sync rising edge, so the window never changes mid-frame.

## Interface
- Parameters: none; all widths are fixed.
- CLK_VIDEO  in  1  clock for all logic.
- RESET_N  in  1  asynchronous, active-low reset.
- VS  in  1  output-side vertical sync, active high; a rising edge commits a staged result.
- HDMI_WIDTH  in  12  output width in pixels.
- HDMI_HEIGHT  in  12  output height in lines.
- ARX  in  13  descriptor X; bit12=1 means bits[11:0] are an absolute width, bit12=0 means a ratio term.
- ARY  in  13  descriptor Y; same encoding as ARX.
- CALC_DONE  out  1  one-cycle pulse when a new result is staged.
- WIN_VALID  out  1  high once the first result has been committed.
- HMIN, HMAX  out  12  first/last active output column.
- VMIN, VMAX  out  12  first/last active output line.

## Operation
- Snapshot registers hold ARX, ARY, HDMI_WIDTH and HDMI_HEIGHT. A pending flag is set at reset.
- FSM states: IDLE, LOAD, MUL1, DIV1, MUL2, DIV2, CENTER.
- IDLE: if pending, or any input differs from its snapshot, go to LOAD and clear pending.
- LOAD: copy the inputs into the snapshot.
  - Full-screen path: both bit12 clear and either low field zero. Set w=HDMI_WIDTH, h=HDMI_HEIGHT; go to CENTER.
  - Absolute path: ARX[12] or ARY[12] set. Set w=min(ARX[11:0],HDMI_WIDTH) and h=min(ARY[11:0],HDMI_HEIGHT). A zero field is replaced by the full dimension. Go to CENTER.
  - Otherwise go to MUL1.
- MUL1: 12-cycle shift-add product P=HDMI_HEIGHT*ARX[11:0], 24 bits.
- DIV1: 24-cycle restoring divide Q=P/ARY[11:0], floor, 24-bit quotient.
  - If Q<=HDMI_WIDTH: w=max(Q,1), h=HDMI_HEIGHT; go to CENTER.
  - Otherwise go to MUL2.
- MUL2: 12-cycle product P=HDMI_WIDTH*ARY[11:0].
- DIV2: 24-cycle divide Q=P/ARX[11:0]. Set h=max(min(Q,HDMI_HEIGHT),1) and w=HDMI_WIDTH; go to CENTER.
- CENTER: compute the staged window, return to IDLE, and pulse CALC_DONE on the next cycle.
  - hmin=(HDMI_WIDTH-w)>>1, hmax=hmin+w-1.
  - vmin=(HDMI_HEIGHT-h)>>1, vmax=vmin+h-1.
  - All arithmetic is 12-bit unsigned; w<=HDMI_WIDTH and h<=HDMI_HEIGHT, so nothing wraps.
- Inputs that change during a calculation do not abort it. The change is detected in the following IDLE cycle and triggers a new calculation.
- Commit: VS is registered, and a rising edge is detected as VS & ~vs_d.
  - On that edge, if a staged result is newer than the committed one, copy it to the outputs and set WIN_VALID=1.
  - Commit uses the staged registers as they were before the current cycle. If CALC_DONE coincides with the VS edge, the new result waits for the next VS edge.
  - Edges with no new result leave the outputs unchanged.
- Reset (asynchronous, also mid-calculation): FSM=IDLE, pending=1, staged and committed values cleared.

## Timing
- Reset values: CALC_DONE=0, WIN_VALID=0, HMIN=HMAX=VMIN=VMAX=0.
- t is the IDLE cycle that detects a change. CALC_DONE is high in:
  - cycle t+3 on the full-screen and absolute paths;
  - cycle t+39 on the ratio path without swap;
  - cycle t+75 on the ratio path with swap.
- Outputs update on the clock edge after the first qualifying VS rising edge is registered.
- The minimum interval between calculations is one IDLE cycle.

## Test plan
- HDMI 1920x1080, ARX=4, ARY=3, reset released, VS pulsed after CALC_DONE:
  - CALC_DONE at t+39;
  - committed window HMIN=240, HMAX=1679, VMIN=0, VMAX=1079; WIN_VALID=1.
- HDMI 1920x1080, ARX=21, ARY=9 (swap path, 17280/21 floors to 822):
  - CALC_DONE at t+75;
  - HMIN=0, HMAX=1919, VMIN=129, VMAX=950.
- HDMI 1920x1080, ARX=0x1000|1280, ARY=0x1000|960 (absolute):
  - CALC_DONE at t+3;
  - HMIN=320, HMAX=1599, VMIN=60, VMAX=1019.
- ARX=0, ARY=3 (full screen):
  - HMIN=0, HMAX=1919, VMIN=0, VMAX=1079;
  - change ARY to 0: a recalculation runs and produces the same window.
- Commit gating:
  - after a committed 4:3 result, change to 16:9 and hold VS low: outputs stay at the 4:3 window after CALC_DONE;
  - the next VS rise gives HMIN=0, HMAX=1919.
  - A VS rise in the same cycle as CALC_DONE does not commit; the following VS rise does.
- Reset mid-calculation:
  - assert RESET_N=0 during DIV1: all outputs read 0 immediately and WIN_VALID=0;
  - after release, a full recalculation gives CALC_DONE at t+39 with correct values.
